// File: rtl/circle_raster_pkg.sv
// Shared types and width helpers for the circle rasteriser.
package circle_raster_pkg;

    typedef enum logic [1:0] {
        OUTLINE = 2'd0,
        FILLED  = 2'd1,
        CLEAR   = 2'd2
    } mode_t;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE  = 3'd0;
    localparam state_t S_EMIT  = 3'd1;
    localparam state_t S_SPAN  = 3'd2;
    localparam state_t S_STEP  = 3'd3;
    localparam state_t S_CLEAR = 3'd4;
    localparam state_t S_FIN   = 3'd5;

    // Signed candidate coordinates carry two extra bits; the decision variable four.
    localparam int unsigned COORD_EXT = 2;
    localparam int unsigned DEC_EXT   = 4;

endpackage

// File: rtl/circle_raster_if.sv
// Job request and pixel stream bundle between the rasteriser and its neighbours.
interface circle_raster_if #(
    parameter int unsigned X_W   = 8,
    parameter int unsigned Y_W   = 7,
    parameter int unsigned R_W   = 8,
    parameter int unsigned COL_W = 3
);
    logic             start;
    logic [1:0]       mode;
    logic [X_W-1:0]   xc;
    logic [Y_W-1:0]   yc;
    logic [R_W-1:0]   radius;
    logic [COL_W-1:0] colour;
    logic             pix_valid;
    logic             pix_ready;
    logic [X_W-1:0]   pix_x;
    logic [Y_W-1:0]   pix_y;
    logic [COL_W-1:0] pix_colour;
    logic             busy;
    logic             done;

    modport master (
        input  start, mode, xc, yc, radius, colour, pix_ready,
        output pix_valid, pix_x, pix_y, pix_colour, busy, done
    );

    modport slave (
        output start, mode, xc, yc, radius, colour, pix_ready,
        input  pix_valid, pix_x, pix_y, pix_colour, busy, done
    );
endinterface

// File: rtl/circle_raster_clip.sv
// Screen-bounds test for one signed candidate; passes through truncated coordinates.
module circle_raster_clip
    import circle_raster_pkg::*;
#(
    parameter int unsigned X_W   = 8,
    parameter int unsigned Y_W   = 7,
    parameter int unsigned X_MAX = 159,
    parameter int unsigned Y_MAX = 119
) (
    input  logic signed [X_W+COORD_EXT-1:0] cx,
    input  logic signed [Y_W+COORD_EXT-1:0] cy,
    output logic                            in_bounds,
    output logic [X_W-1:0]                  px,
    output logic [Y_W-1:0]                  py
);
    localparam int unsigned XS = X_W + COORD_EXT;
    localparam int unsigned YS = Y_W + COORD_EXT;
    localparam logic signed [XS-1:0] X_LAST = XS'(X_MAX);
    localparam logic signed [YS-1:0] Y_LAST = YS'(Y_MAX);

    assign in_bounds = !cx[XS-1] && (cx <= X_LAST) && !cy[YS-1] && (cy <= Y_LAST);
    assign px = cx[X_W-1:0];
    assign py = cy[Y_W-1:0];
endmodule

// File: rtl/circle_raster.sv
// Handshaked circle engine: midpoint outline, span fill and screen clear.
module circle_raster
    import circle_raster_pkg::*;
#(
    parameter int unsigned X_W   = 8,
    parameter int unsigned Y_W   = 7,
    parameter int unsigned R_W   = 8,
    parameter int unsigned COL_W = 3,
    parameter int unsigned X_MAX = 159,
    parameter int unsigned Y_MAX = 119
) (
    input logic            clock,
    input logic            reset,
    circle_raster_if.master bus
);
    localparam int unsigned XS = X_W + COORD_EXT;
    localparam int unsigned YS = Y_W + COORD_EXT;
    localparam int unsigned DW = R_W + DEC_EXT;
    localparam int unsigned RY = R_W + 1;
    localparam logic signed [XS-1:0] X_LAST = XS'(X_MAX);
    localparam logic signed [RY-1:0] Y_LAST = RY'(Y_MAX);

    state_t                  state, n_state;
    logic [2:0]              k, n_k, kn;
    logic signed [XS-1:0]    col, n_col;
    logic signed [RY-1:0]    x, y, n_x, n_y, sx, sy;
    logic signed [DW-1:0]    d, n_d, sd, dx, dy;
    logic [X_W-1:0]          cx, n_cx;
    logic [Y_W-1:0]          cy, n_cy;
    logic [COL_W-1:0]        colour_q, n_colour;
    logic                    filled, n_filled;
    logic                    adv, emit_n, inb;
    logic signed [XS-1:0]    cxs, hx, hy, span_right, next_left;
    logic signed [XS-1:0]    ncx, vx_x, vy_x, cand_x;
    logic signed [YS-1:0]    ncy, vx_y, vy_y, cand_y;
    logic [X_W-1:0]          clip_x;
    logic [Y_W-1:0]          clip_y;

    // One midpoint iteration; y may go to -1 so the x<=y exit test stays signed.
    always_comb begin
        dx = DW'(x);
        dy = DW'(y);
        if (d[DW-1]) begin
            sd = d + (dx <<< 2) + DW'(6);
            sy = y;
        end else begin
            sd = d + ((dx - dy) <<< 2) + DW'(10);
            sy = y - RY'(1);
        end
        sx = x + RY'(1);
    end

    always_comb begin
        cxs        = XS'(cx);
        hx         = XS'(x);
        hy         = XS'(y);
        kn         = k + 3'd1;
        span_right = cxs + (k[1] ? hy : hx);
        next_left  = cxs - (kn[1] ? hy : hx);
    end

    always_comb begin
        adv      = !bus.pix_valid || bus.pix_ready;
        n_state  = state;
        n_k      = k;
        n_col    = col;
        n_x      = x;
        n_y      = y;
        n_d      = d;
        n_cx     = cx;
        n_cy     = cy;
        n_colour = colour_q;
        n_filled = filled;
        case (state)
            S_IDLE: if (bus.start) begin
                n_cx     = bus.xc;
                n_cy     = bus.yc;
                n_x      = '0;
                n_y      = signed'({1'b0, bus.radius});
                n_d      = DW'(3) - (DW'(bus.radius) <<< 1);
                n_k      = '0;
                n_col    = XS'(bus.xc);
                n_colour = bus.colour;
                n_filled = 1'b0;
                case (bus.mode)
                    FILLED: begin
                        n_state  = S_SPAN;
                        n_filled = 1'b1;
                    end
                    CLEAR: begin
                        n_state  = S_CLEAR;
                        n_colour = '0;
                        n_col    = '0;
                        n_y      = '0;
                    end
                    default: n_state = S_EMIT;
                endcase
            end
            S_EMIT: if (adv) begin
                if (k == 3'd7) n_state = S_STEP;
                else           n_k = kn;
            end
            S_SPAN: if (adv) begin
                if (col == span_right) begin
                    if (k == 3'd3) n_state = S_STEP;
                    else begin
                        n_k   = kn;
                        n_col = next_left;
                    end
                end else begin
                    n_col = col + XS'(1);
                end
            end
            S_STEP: begin
                n_x   = sx;
                n_y   = sy;
                n_d   = sd;
                n_k   = '0;
                n_col = cxs - XS'(sx);
                if (sx <= sy) n_state = filled ? S_SPAN : S_EMIT;
                else          n_state = S_FIN;
            end
            S_CLEAR: if (adv) begin
                if (col == X_LAST) begin
                    n_col = '0;
                    if (y == Y_LAST) n_state = S_FIN;
                    else             n_y = y + RY'(1);
                end else begin
                    n_col = col + XS'(1);
                end
            end
            S_FIN:   n_state = S_IDLE;
            default: n_state = S_IDLE;
        endcase
    end

    // Candidate for the slot being loaded, built from next-state values so the
    // first pixel is registered on the same edge that samples start.
    always_comb begin
        ncx    = XS'(n_cx);
        ncy    = YS'(n_cy);
        vx_x   = XS'(n_x);
        vy_x   = XS'(n_y);
        vx_y   = YS'(n_x);
        vy_y   = YS'(n_y);
        cand_x = '0;
        cand_y = '0;
        emit_n = (n_state == S_EMIT) || (n_state == S_SPAN) || (n_state == S_CLEAR);
        case (n_state)
            S_EMIT: case (n_k)
                3'd0: begin cand_x = ncx + vx_x; cand_y = ncy + vy_y; end
                3'd1: begin cand_x = ncx - vx_x; cand_y = ncy + vy_y; end
                3'd2: begin cand_x = ncx + vx_x; cand_y = ncy - vy_y; end
                3'd3: begin cand_x = ncx - vx_x; cand_y = ncy - vy_y; end
                3'd4: begin cand_x = ncx + vy_x; cand_y = ncy + vx_y; end
                3'd5: begin cand_x = ncx - vy_x; cand_y = ncy + vx_y; end
                3'd6: begin cand_x = ncx + vy_x; cand_y = ncy - vx_y; end
                default: begin cand_x = ncx - vy_x; cand_y = ncy - vx_y; end
            endcase
            S_SPAN: begin
                cand_x = n_col;
                case (n_k[1:0])
                    2'd0:    cand_y = ncy + vy_y;
                    2'd1:    cand_y = ncy - vy_y;
                    2'd2:    cand_y = ncy + vx_y;
                    default: cand_y = ncy - vx_y;
                endcase
            end
            S_CLEAR: begin
                cand_x = n_col;
                cand_y = vy_y;
            end
            default: ;
        endcase
    end

    circle_raster_clip #(
        .X_W   (X_W),
        .Y_W   (Y_W),
        .X_MAX (X_MAX),
        .Y_MAX (Y_MAX)
    ) u_clip (
        .cx        (cand_x),
        .cy        (cand_y),
        .in_bounds (inb),
        .px        (clip_x),
        .py        (clip_y)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state          <= S_IDLE;
            k              <= '0;
            col            <= '0;
            x              <= '0;
            y              <= '0;
            d              <= '0;
            cx             <= '0;
            cy             <= '0;
            colour_q       <= '0;
            filled         <= 1'b0;
            bus.pix_valid  <= 1'b0;
            bus.pix_x      <= '0;
            bus.pix_y      <= '0;
            bus.pix_colour <= '0;
            bus.busy       <= 1'b0;
            bus.done       <= 1'b0;
        end else begin
            state         <= n_state;
            k             <= n_k;
            col           <= n_col;
            x             <= n_x;
            y             <= n_y;
            d             <= n_d;
            cx            <= n_cx;
            cy            <= n_cy;
            colour_q      <= n_colour;
            filled        <= n_filled;
            bus.pix_valid <= emit_n && inb;
            if (emit_n && inb) begin
                bus.pix_x      <= clip_x;
                bus.pix_y      <= clip_y;
                bus.pix_colour <= n_colour;
            end
            bus.busy <= (n_state != S_IDLE) && (n_state != S_FIN);
            bus.done <= (n_state == S_FIN);
        end
    end
endmodule

// File: tb/tb_circle_raster.sv
// Randomised bench for circle_raster against a plain-integer midpoint/span reference.
module tb_circle_raster;
    localparam int X_MAX = 159;
    localparam int Y_MAX = 119;

    logic clk = 1'b0;
    logic rst = 1'b0;

    circle_raster_if #(.X_W(8), .Y_W(7), .R_W(8), .COL_W(3)) bus ();

    circle_raster #(
        .X_W(8), .Y_W(7), .R_W(8), .COL_W(3), .X_MAX(159), .Y_MAX(119)
    ) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int exp_q[$];
    int got_q[$];
    int exp_cycles;
    int done_cyc, done_width, stall_err, busy_first, busy_at_done, bad_coord;
    bit timed_out;

    function automatic int pk(input int px, input int py, input int pc);
        return (px << 16) | (py << 8) | pc;
    endfunction

    function automatic void push_pt(input int px, input int py, input int pc);
        if (px >= 0 && px <= X_MAX && py >= 0 && py <= Y_MAX) exp_q.push_back(pk(px, py, pc));
    endfunction

    // Reference: every candidate costs one slot, every iteration one step slot, then FIN.
    function automatic void build_model(input int m, input int xc, input int yc, input int r, input int c);
        int x, y, d, slots;
        int rows[4];
        int halves[4];
        int ox[8];
        int oy[8];
        exp_q.delete();
        slots = 0;
        if (m == 2) begin
            for (int yy = 0; yy <= Y_MAX; yy++)
                for (int xx = 0; xx <= X_MAX; xx++) push_pt(xx, yy, 0);
            exp_cycles = (X_MAX + 1) * (Y_MAX + 1) + 1;
            return;
        end
        x = 0; y = r; d = 3 - 2 * r;
        do begin
            if (m == 1) begin
                rows   = '{yc + y, yc - y, yc + x, yc - x};
                halves = '{x, x, y, y};
                for (int s = 0; s < 4; s++)
                    for (int cc = xc - halves[s]; cc <= xc + halves[s]; cc++) begin
                        push_pt(cc, rows[s], c);
                        slots++;
                    end
            end else begin
                ox = '{x, -x, x, -x, y, -y, y, -y};
                oy = '{y, y, -y, -y, x, x, -x, -x};
                for (int o = 0; o < 8; o++) begin
                    push_pt(xc + ox[o], yc + oy[o], c);
                    slots++;
                end
            end
            slots++;
            if (d < 0) d += 4 * x + 6;
            else begin
                d += 4 * (x - y) + 10;
                y--;
            end
            x++;
        end while (x <= y);
        exp_cycles = slots + 1;
    endfunction

    function automatic int count_diff(output int first_bad);
        int n = 0;
        int len = (got_q.size() > exp_q.size()) ? got_q.size() : exp_q.size();
        first_bad = -1;
        for (int i = 0; i < len; i++)
            if (i >= got_q.size() || i >= exp_q.size() || got_q[i] != exp_q[i]) begin
                n++;
                if (first_bad < 0) first_bad = i;
            end
        return n;
    endfunction

    task automatic run_job(input int m, input int xc, input int yc, input int r, input int c,
                           input int ready_pct, input int max_cycles, input int poke_cycle);
        int cyc, px, py, pc;
        bit rdy, prev_stall;
        got_q.delete();
        stall_err = 0; done_cyc = -1; timed_out = 0; prev_stall = 0; bad_coord = 0;
        px = 0; py = 0; pc = 0; busy_at_done = -1;
        bus.mode = m[1:0]; bus.xc = xc[7:0]; bus.yc = yc[6:0];
        bus.radius = r[7:0]; bus.colour = c[2:0]; bus.pix_ready = 1'b0;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        cyc = 1;
        busy_first = bus.busy;
        forever begin
            if (bus.done) begin
                done_cyc = cyc;
                busy_at_done = bus.busy;
                break;
            end
            if (cyc > max_cycles) begin
                timed_out = 1;
                break;
            end
            if (prev_stall && (bus.pix_valid !== 1'b1 || bus.pix_x !== px[7:0] ||
                               bus.pix_y !== py[6:0] || bus.pix_colour !== pc[2:0]))
                stall_err++;
            rdy = ($urandom_range(99) < ready_pct);
            bus.pix_ready = rdy;
            if (bus.pix_valid && rdy) begin
                got_q.push_back(pk(bus.pix_x, bus.pix_y, bus.pix_colour));
                if (bus.pix_x > X_MAX || bus.pix_y > Y_MAX) bad_coord++;
            end
            prev_stall = bus.pix_valid && !rdy;
            px = bus.pix_x; py = bus.pix_y; pc = bus.pix_colour;
            if (cyc == poke_cycle) begin
                bus.start = 1'b1;
                bus.mode = 2'd0;
                bus.xc = 8'd5; bus.yc = 7'd5; bus.radius = 8'd2; bus.colour = 3'd7;
            end else begin
                bus.start = 1'b0;
            end
            @(posedge clk); #1;
            cyc++;
        end
        bus.pix_ready = 1'b0;
        bus.start = 1'b0;
        @(posedge clk); #1;
        done_width = bus.done ? 2 : 1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #12;
        total++; if (bus.pix_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", bus.pix_valid); end
        total++; if (bus.pix_x !== 8'd0) begin bad++; $display("FAIL reset_x: got %0d want 0", bus.pix_x); end
        total++; if (bus.pix_y !== 7'd0) begin bad++; $display("FAIL reset_y: got %0d want 0", bus.pix_y); end
        total++; if (bus.pix_colour !== 3'd0) begin bad++; $display("FAIL reset_colour: got %0d want 0", bus.pix_colour); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", bus.done); end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_outline_r0();
        int nbad = 0;
        build_model(0, 80, 60, 0, 5);
        run_job(0, 80, 60, 0, 5, 100, 200, 0);
        total++; if (timed_out) begin bad++; $display("FAIL r0_timeout: got timeout want done"); end
        total++; if (got_q.size() != 8) begin bad++; $display("FAIL r0_count: got %0d want 8", got_q.size()); end
        foreach (got_q[i]) if (got_q[i] != pk(80, 60, 5)) nbad++;
        total++; if (nbad != 0) begin bad++; $display("FAIL r0_pixels: got %0d wrong want 0", nbad); end
        total++; if (done_cyc != exp_cycles) begin bad++; $display("FAIL r0_latency: got %0d want %0d", done_cyc, exp_cycles); end
        total++; if (busy_first !== 1) begin bad++; $display("FAIL r0_busy_rise: got %0d want 1", busy_first); end
        total++; if (busy_at_done !== 0) begin bad++; $display("FAIL r0_busy_at_done: got %0d want 0", busy_at_done); end
        total++; if (done_width != 1) begin bad++; $display("FAIL r0_done_width: got %0d want 1", done_width); end
    endtask

    task automatic test_outline_r1();
        int want[8];
        int nbad = 0;
        want = '{pk(80,61,2), pk(80,61,2), pk(80,59,2), pk(80,59,2),
                 pk(81,60,2), pk(79,60,2), pk(81,60,2), pk(79,60,2)};
        run_job(3, 80, 60, 1, 2, 100, 200, 0);
        total++; if (got_q.size() != 8) begin bad++; $display("FAIL r1_count: got %0d want 8", got_q.size()); end
        for (int i = 0; i < 8; i++)
            if (i >= got_q.size() || got_q[i] != want[i]) nbad++;
        total++; if (nbad != 0) begin bad++; $display("FAIL r1_order: got %0d wrong want 0", nbad); end
        total++; if (done_cyc != 10) begin bad++; $display("FAIL r1_latency: got %0d want 10", done_cyc); end
    endtask

    task automatic test_outline_clip();
        int fb, diff;
        build_model(0, 2, 2, 5, 6);
        run_job(0, 2, 2, 5, 6, 100, 500, 0);
        diff = count_diff(fb);
        total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL clip_count: got %0d want %0d", got_q.size(), exp_q.size()); end
        total++; if (diff != 0) begin bad++; $display("FAIL clip_pixels: got %0d mismatches (first %0d) want 0", diff, fb); end
        total++; if (bad_coord != 0) begin bad++; $display("FAIL clip_range: got %0d off-screen want 0", bad_coord); end
        total++; if (done_cyc != exp_cycles) begin bad++; $display("FAIL clip_latency: got %0d want %0d", done_cyc, exp_cycles); end
    endtask

    task automatic test_random_outline();
        int fb, diff, m, xc, yc, r, c;
        for (int j = 0; j < 6; j++) begin
            m = ($urandom_range(1) == 1) ? 3 : 0;
            xc = $urandom_range(159); yc = $urandom_range(119);
            r = $urandom_range(40); c = $urandom_range(7);
            build_model(m, xc, yc, r, c);
            run_job(m, xc, yc, r, c, 100, 2000, 0);
            diff = count_diff(fb);
            total++; if (diff != 0) begin bad++; $display("FAIL rand_outline_pixels: job %0d got %0d mismatches (first %0d) want 0", j, diff, fb); end
            total++; if (done_cyc != exp_cycles) begin bad++; $display("FAIL rand_outline_latency: job %0d got %0d want %0d", j, done_cyc, exp_cycles); end
        end
    endtask

    task automatic test_filled_stall();
        int fb, diff, xc, yc, r, c;
        for (int j = 0; j < 4; j++) begin
            if (j == 0) begin xc = 10; yc = 10; r = 3; c = 4; end
            else begin
                xc = $urandom_range(159); yc = $urandom_range(119);
                r = $urandom_range(15); c = $urandom_range(7);
            end
            build_model(1, xc, yc, r, c);
            run_job(1, xc, yc, r, c, 50, 5000, 0);
            diff = count_diff(fb);
            total++; if (timed_out) begin bad++; $display("FAIL filled_timeout: job %0d got timeout want done", j); end
            total++; if (diff != 0) begin bad++; $display("FAIL filled_pixels: job %0d got %0d mismatches (first %0d) want 0", j, diff, fb); end
            total++; if (stall_err != 0) begin bad++; $display("FAIL filled_stall_stable: job %0d got %0d changes want 0", j, stall_err); end
        end
    endtask

    task automatic test_clear();
        int fb, diff;
        build_model(2, 0, 0, 0, 0);
        run_job(2, 33, 44, 9, 5, 100, 20000, 100);
        diff = count_diff(fb);
        total++; if (got_q.size() != 19200) begin bad++; $display("FAIL clear_count: got %0d want 19200", got_q.size()); end
        total++; if (diff != 0) begin bad++; $display("FAIL clear_order: got %0d mismatches (first %0d) want 0", diff, fb); end
        total++; if (done_cyc != exp_cycles) begin bad++; $display("FAIL clear_latency: got %0d want %0d", done_cyc, exp_cycles); end
    endtask

    task automatic test_reset_mid_job();
        int dones = 0;
        int fb, diff;
        bus.mode = 2'd1; bus.xc = 8'd80; bus.yc = 7'd60; bus.radius = 8'd30;
        bus.colour = 3'd3; bus.pix_ready = 1'b1; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int i = 0; i < 40; i++) begin @(posedge clk); #1; end
        rst = 1'b1;
        #1;
        total++; if (bus.pix_valid !== 1'b0) begin bad++; $display("FAIL midreset_valid: got %b want 0", bus.pix_valid); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL midreset_busy: got %b want 0", bus.busy); end
        @(posedge clk); #1;
        rst = 1'b0;
        bus.pix_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.done) dones++;
            @(posedge clk); #1;
        end
        total++; if (dones != 0) begin bad++; $display("FAIL midreset_no_done: got %0d pulses want 0", dones); end
        build_model(0, 40, 30, 12, 1);
        run_job(0, 40, 30, 12, 1, 100, 1000, 0);
        diff = count_diff(fb);
        total++; if (diff != 0) begin bad++; $display("FAIL midreset_recover: got %0d mismatches (first %0d) want 0", diff, fb); end
        total++; if (done_cyc != exp_cycles) begin bad++; $display("FAIL midreset_latency: got %0d want %0d", done_cyc, exp_cycles); end
    endtask

    initial begin
        bus.start = 1'b0; bus.mode = 2'd0; bus.xc = '0; bus.yc = '0;
        bus.radius = '0; bus.colour = '0; bus.pix_ready = 1'b0;
        test_reset();
        test_outline_r0();
        test_outline_r1();
        test_outline_clip();
        test_random_outline();
        test_filled_stall();
        test_clear();
        test_reset_mid_job();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
